decode_stage: RTL and testbench



---
 rtl/simple_processor_pkg.sv | 38 +++
 rtl/decode_stage_scoreboard.sv | 39 +++
 rtl/decode_stage.sv | 156 +++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor pipeline.
// Instruction field layout and decoded micro-op bundle.
package simple_processor_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int DATA_WIDTH     = 32;
  localparam int IMM_WIDTH      = 6;

  localparam int FUNC_LSB = 0;
  localparam int FUNC_MSB = 3;
  localparam int RD_LSB   = 4;
  localparam int RD_MSB   = 8;
  localparam int RS1_LSB  = 9;
  localparam int RS1_MSB  = 13;
  localparam int RS2_LSB  = 14;
  localparam int RS2_MSB  = 18;
  localparam int IMM_LSB  = 19;
  localparam int IMM_MSB  = 24;

  typedef enum logic [3:0] {
    FUNC_ADD  = 4'h0,
    FUNC_SUB  = 4'h1,
    FUNC_ADDI = 4'h2
  } func_t;

  typedef struct packed {
    func_t                     func;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [IMM_WIDTH-1:0]      imm;
    logic                      uses_rs2;
    logic                      legal;
  } decoded_instr_t;

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Pending-write bits per architectural register.
// Set and clear in one cycle on the same bit: set wins.
module reg_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_i,
  input  logic [REG_ADDR_WIDTH-1:0] set_idx_i,
  input  logic [NUM_REGS-1:0]       clr_mask_i,
  input  logic [REG_ADDR_WIDTH-1:0] lk_a_idx_i,
  output logic                      lk_a_o,
  input  logic [REG_ADDR_WIDTH-1:0] lk_b_idx_i,
  output logic                      lk_b_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q & ~clr_mask_i;
    if (set_i && (set_idx_i != '0)) begin
      pending_d[set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign lk_a_o = pending_q[lk_a_idx_i];
  assign lk_b_o = pending_q[lk_b_idx_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetch words, reads the RF, interlocks RAW
// hazards and holds one registered micro-op for execute.
module decode_stage
  import simple_processor_pkg::*;
#(
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [INSTR_WIDTH-1:0]    instr_i,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output func_t                     ex_func_o,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data_o,
  output logic [IMM_WIDTH-1:0]      ex_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                      flush_i,
  output logic                      illegal_o
);

  decoded_instr_t dec;
  logic [3:0]     fn;
  logic           unused_hi;

  assign fn        = instr_i[FUNC_MSB:FUNC_LSB];
  assign unused_hi = ^instr_i[INSTR_WIDTH-1:IMM_MSB+1];

  always_comb begin
    dec          = '0;
    dec.func     = func_t'(fn);
    dec.rd       = instr_i[RD_MSB:RD_LSB];
    dec.rs1      = instr_i[RS1_MSB:RS1_LSB];
    dec.rs2      = instr_i[RS2_MSB:RS2_LSB];
    dec.imm      = instr_i[IMM_MSB:IMM_LSB];
    unique case (1'b1)
      (fn == FUNC_ADD),
      (fn == FUNC_SUB): begin
        dec.legal    = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      (fn == FUNC_ADDI): begin
        dec.legal    = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_rs1_addr_o = dec.rs1;
  assign rf_rs2_addr_o = dec.rs2;

  logic                      ex_valid_q, ex_valid_d;
  func_t                     ex_func_q, ex_func_d;
  logic [DATA_WIDTH-1:0]     ex_rs1_q, ex_rs1_d;
  logic [DATA_WIDTH-1:0]     ex_rs2_q, ex_rs2_d;
  logic [IMM_WIDTH-1:0]      ex_imm_q, ex_imm_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                      illegal_q, illegal_d;

  logic                pend_rs1, pend_rs2;
  logic                hazard, slot_free, accept, issue;
  logic [NUM_REGS-1:0] clr_mask;

  // Interlock uses registered pending bits only; no bypass path.
  assign hazard        = pend_rs1 | (dec.uses_rs2 & pend_rs2);
  assign slot_free     = ~ex_valid_q | ex_ready_i;
  assign instr_ready_o = slot_free & ~hazard & ~flush_i;
  assign accept        = instr_valid_i & instr_ready_o;
  assign issue         = accept & dec.legal;

  always_comb begin
    clr_mask = '0;
    if (wb_valid_i) begin
      clr_mask[wb_rd_i] = 1'b1;
    end
    if (flush_i && ex_valid_q) begin
      clr_mask[ex_rd_q] = 1'b1;
    end
  end

  reg_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (issue),
    .set_idx_i  (dec.rd),
    .clr_mask_i (clr_mask),
    .lk_a_idx_i (dec.rs1),
    .lk_a_o     (pend_rs1),
    .lk_b_idx_i (dec.rs2),
    .lk_b_o     (pend_rs2)
  );

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_func_d  = ex_func_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    illegal_d  = accept & ~dec.legal;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_func_d  = dec.func;
      ex_rs1_d   = rf_rs1_data_i;
      ex_rs2_d   = rf_rs2_data_i;
      ex_imm_d   = dec.imm;
      ex_rd_d    = dec.rd;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_func_q  <= FUNC_ADD;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_func_q  <= ex_func_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_func_o     = ex_func_q;
  assign ex_rs1_data_o = ex_rs1_q;
  assign ex_rs2_data_o = ex_rs2_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_o       = ex_rd_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage with a
// transaction-level reference model.
module tb_decode_stage;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  func_t       ex_func_o;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o;
  logic [5:0]  ex_imm_o;
  logic [4:0]  ex_rd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        illegal_o;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .rf_rs1_addr_o (rf_rs1_addr_o),
    .rf_rs2_addr_o (rf_rs2_addr_o),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .ex_func_o     (ex_func_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rd_o       (ex_rd_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .flush_i       (flush_i),
    .illegal_o     (illegal_o)
  );

  logic [31:0] rf [32];
  assign rf_rs1_data_i = rf[rf_rs1_addr_o];
  assign rf_rs2_data_i = rf[rf_rs2_addr_o];

  typedef struct {
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  imm;
    logic [4:0]  rd;
    logic        chk_b;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  logic        m_valid = 0, n_valid = 0;
  logic        m_ill   = 0, n_ill   = 0;
  logic [4:0]  m_rd    = 0, n_rd    = 0;
  logic [31:0] m_pend  = 0, n_pend  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] rd,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [5:0] imm);
    return {7'h0, imm, r2, r1, rd, f};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic exr,
                      input logic wbv, input logic [4:0] wbrd, input logic fl);
    logic [3:0] f;
    logic [4:0] rd, r1, r2;
    logic       legal, use2, hz, er, acc;
    @(posedge clk);
    #2;
    m_valid = n_valid;
    m_ill   = n_ill;
    m_rd    = n_rd;
    m_pend  = n_pend;
    chk("ex_valid", ex_valid_o, m_valid);
    chk("illegal", illegal_o, m_ill);
    chk("pending", dut.u_scoreboard.pending_q, m_pend);
    instr_valid_i = v;
    instr_i       = ins;
    ex_ready_i    = exr;
    wb_valid_i    = wbv;
    wb_rd_i       = wbrd;
    flush_i       = fl;
    #1;
    f     = ins[3:0];
    rd    = ins[8:4];
    r1    = ins[13:9];
    r2    = ins[18:14];
    legal = (f == 4'h0) || (f == 4'h1) || (f == 4'h2);
    use2  = (f == 4'h0) || (f == 4'h1);
    hz    = m_pend[r1] || (use2 && m_pend[r2]);
    er    = (!m_valid || exr) && !hz && !fl;
    chk("instr_ready", instr_ready_o, er);
    acc = v && er;
    n_pend = m_pend;
    if (wbv && wbrd != 0) n_pend[wbrd] = 1'b0;
    if (fl && m_valid) begin
      if (m_rd != 0) n_pend[m_rd] = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    if (acc && legal && rd != 0) n_pend[rd] = 1'b1;
    n_ill = acc && !legal;
    if (fl) n_valid = 1'b0;
    else if (acc && legal) n_valid = 1'b1;
    else if (exr) n_valid = 1'b0;
    else n_valid = m_valid;
    n_rd = m_rd;
    if (acc && legal) begin
      n_rd = rd;
      exp_q.push_back('{f, rf[r1], rf[r2], ins[24:19], rd, use2});
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && ex_valid_o && ex_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("out_expected", ex_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("ex_func", ex_func_o, e.func);
          chk("ex_rs1_data", ex_rs1_data_o, e.a);
          if (e.chk_b) chk("ex_rs2_data", ex_rs2_data_o, e.b);
          chk("ex_imm", ex_imm_o, e.imm);
          chk("ex_rd", ex_rd_o, e.rd);
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [3:0]  f;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rst_i = 1'b1;
    instr_valid_i = 0; instr_i = 0; ex_ready_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_func", ex_func_o, 0);
    chk("rst_rs1", ex_rs1_data_o, 0);
    chk("rst_rs2", ex_rs2_data_o, 0);
    chk("rst_imm", ex_imm_o, 0);
    chk("rst_rd", ex_rd_o, 0);
    chk("rst_pending", dut.u_scoreboard.pending_q, 0);

    // ADD x3 = x1 + x2, then dependent ADDI stalls until writeback of x3
    step(1, mk(FUNC_ADD, 3, 1, 2, 0), 1, 0, 0, 0);
    step(1, mk(FUNC_ADDI, 4, 3, 0, 6'h3F), 1, 0, 0, 0);
    step(1, mk(FUNC_ADDI, 4, 3, 0, 6'h3F), 1, 0, 0, 0);
    step(1, mk(FUNC_ADDI, 4, 3, 0, 6'h3F), 1, 1, 3, 0);
    step(1, mk(FUNC_ADDI, 4, 3, 0, 6'h3F), 0, 0, 0, 0);
    // back-pressure for three cycles, then back-to-back transfer
    step(1, mk(FUNC_SUB, 7, 1, 2, 0), 0, 0, 0, 0);
    step(1, mk(FUNC_SUB, 7, 1, 2, 0), 0, 0, 0, 0);
    step(1, mk(FUNC_SUB, 7, 1, 2, 0), 0, 0, 0, 0);
    step(1, mk(FUNC_SUB, 7, 1, 2, 0), 1, 1, 4, 0);
    step(1, mk(4'hF, 9, 1, 2, 0), 1, 1, 7, 0);
    step(0, 0, 1, 0, 0, 0);
    // held ADD to x5 dropped by flush
    step(1, mk(FUNC_ADD, 5, 1, 2, 0), 0, 0, 0, 0);
    step(1, mk(FUNC_ADD, 8, 1, 2, 0), 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    // issue and writeback to x6 in the same cycle
    step(1, mk(FUNC_ADD, 6, 1, 2, 0), 1, 1, 6, 0);
    step(1, mk(FUNC_ADD, 0, 1, 2, 0), 1, 1, 6, 0);
    step(1, mk(FUNC_ADD, 0, 0, 0, 0), 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2))
                                     : 4'($urandom_range(0, 15));
      ins = mk(f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 6'($urandom));
      ins[31:25] = 7'($urandom);
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
